i2c_txn_arbiter: RTL and testbench
==================================

Name: i2c_txn_arbiter

Overview:
Shares one I2CController between NUM_REQ independent requesters (sensor poller, config loader, debug port, and so on). It arbitrates round-robin, latches the winner's transaction, and drives the controller's command inputs. It then waits for completion or timeout and returns the read data and status to the winning requester. It sits directly in front of I2CController; requesters never touch the controller pins.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, register address / data width
TIMEOUT_CYCLES, 4096, clk cycles allowed from newTXN to ctrlDone before abort

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset; synchronous, active-high
reqValid  in  NUM_REQ  per-requester request
reqReady  out  NUM_REQ  one-hot accept; transfer when reqValid[i] & reqReady[i]
reqWrEn  in  NUM_REQ  1 = write, 0 = read
reqSlvAddr  in  NUM_REQ*(DATA_WIDTH-1)  packed 7-bit slave addresses, requester i at slice i
reqRegAddr  in  NUM_REQ*DATA_WIDTH  packed register addresses
reqData  in  NUM_REQ*DATA_WIDTH  packed write data
rspValid  out  1  one-cycle response pulse
rspId  out  $clog2(NUM_REQ)  requester index the response belongs to
rspData  out  DATA_WIDTH  read data (0 for writes and errors)
rspErr  out  2  0 = OK, 1 = NACK, 2 = timeout
wrEn  out  1  to controller
newTXN  out  1  to controller; one-cycle start pulse
slvAddr  out  DATA_WIDTH-1  to controller
regAddr  out  DATA_WIDTH  to controller
dataIn  out  DATA_WIDTH  to controller
ctrlBusy  in  1  controller mid-transaction
ctrlDone  in  1  one-cycle completion pulse from controller
ctrlNack  in  1  valid with ctrlDone; slave NACKed
dataOut  in  DATA_WIDTH  controller read data; valid with ctrlDone

Behaviour:
- Reset values: all outputs 0; state IDLE; rrPtr = 0; timeout counter 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any reqValid is set, grant g is the first set bit searching cyclically from rrPtr.
  - reqReady[g] = 1 in the same cycle; reqReady is combinational and only nonzero in IDLE.
  - Latch g, reqWrEn[g] and the three address/data slices.
  - Next state is ISSUE.
- ISSUE:
  - Controller outputs are driven from the latches and held stable through WAIT.
  - If ctrlBusy = 0, assert newTXN for exactly one cycle, clear the timeout counter and go to WAIT. Otherwise stay, with newTXN = 0.
  - A ctrlDone seen in ISSUE is stale and is ignored.
- WAIT:
  - The counter increments every cycle.
  - On ctrlDone: capture dataOut (forced to 0 if write or ctrlNack) and set err = ctrlNack ? 1 : 0.
  - If the counter reaches TIMEOUT_CYCLES-1 without ctrlDone: err = 2, data = 0.
  - ctrlDone and timeout in the same cycle: ctrlDone wins.
  - Either exit goes to RESP.
- RESP:
  - rspValid = 1 for one cycle, with rspId = g and the captured data and err.
  - rrPtr = (g+1) mod NUM_REQ; newTXN stays 0; next state is IDLE.
- Latency: accept at cycle T, newTXN at T+1 when the controller is idle, response one cycle after ctrlDone.
- Back-to-back: the next accept happens no earlier than the cycle after RESP. There is exactly one outstanding transaction.
- Request rules:
  - Requesters hold their fields stable while reqValid is high.
  - Deasserting reqValid before accept is legal and results in no transaction.
  - Fields of non-granted requesters are don't-care.
- Fairness: a continuously requesting requester is granted within NUM_REQ transactions.
- rst mid-transaction: next cycle is IDLE with all outputs 0 and no response for the aborted transaction. rrPtr returns to 0. The controller is reset by the same rst.
- Width rules: rspId is $clog2(NUM_REQ) bits. rrPtr wrap uses explicit compare, not power-of-two truncation. The timeout counter is $clog2(TIMEOUT_CYCLES) bits and must not wrap before its compare.

Decomposition:
- Shared package i2c_pkg: FSM state enum, rspErr codes (ERR_OK = 0, ERR_NACK = 1, ERR_TIMEOUT = 2), SLV_ADDR_W = 7. The I2CController and future I2C blocks reuse it.
- One sub-module rr_arbiter (NUM_REQ):
  - Combinational grant from the request vector and rrPtr, plus a pointer register advanced by an update strobe.
  - It is reused for other shared buses.

Test Plan:
- Single write: reqValid[0], slvAddr 7'd10, regAddr 8'd1, data 8'd3. Required: reqReady[0] the same cycle, newTXN one cycle later with wrEn = 1, slvAddr 10, regAddr 1, dataIn 3. ctrlDone after 50 cycles gives rspValid next cycle with rspId 0, rspErr 0, rspData 0.
- Read with NACK: requester 2 reads 0x2A/0x10 and the model returns ctrlNack = 1. Required: rspId 2, rspErr 1, rspData 0. A second read returns dataOut 0xA5, giving rspErr 0 and rspData 0xA5.
- Round-robin: all 4 requesters hold reqValid continuously. Required: grant order 0, 1, 2, 3, 0 and exactly one newTXN per response.
- Busy controller and timeout:
  - Hold ctrlBusy = 1 for 20 cycles with reqValid[1] asserted. Required: newTXN not asserted until ctrlBusy falls.
  - Then never return ctrlDone. Required: rspErr 2 exactly TIMEOUT_CYCLES cycles after newTXN.
- Done/timeout collision: ctrlDone arrives on the terminal timeout cycle. Required: rspErr 0 and no second response.
- Reset mid-transaction: assert rst for one cycle during WAIT. Required: all outputs 0 the next cycle and no rspValid. A new request is then served with rrPtr = 0.

Source files
------------

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C types: transaction FSM states, response codes, address width
package i2c_pkg;
    localparam int SLV_ADDR_W = 7;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_NACK    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } txn_state_t;
endpackage

// File: rtl/i2c_txn_arbiter_if.sv
// rtl/i2c_txn_arbiter_if.sv - requester and controller signal bundle around the I2C arbiter
interface i2c_txn_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]                reqValid;
    logic [NUM_REQ-1:0]                reqReady;
    logic [NUM_REQ-1:0]                reqWrEn;
    logic [NUM_REQ*(DATA_WIDTH-1)-1:0] reqSlvAddr;
    logic [NUM_REQ*DATA_WIDTH-1:0]     reqRegAddr;
    logic [NUM_REQ*DATA_WIDTH-1:0]     reqData;
    logic                              rspValid;
    logic [IDW-1:0]                    rspId;
    logic [DATA_WIDTH-1:0]             rspData;
    logic [1:0]                        rspErr;
    logic                              wrEn;
    logic                              newTXN;
    logic [DATA_WIDTH-2:0]             slvAddr;
    logic [DATA_WIDTH-1:0]             regAddr;
    logic [DATA_WIDTH-1:0]             dataIn;
    logic                              ctrlBusy;
    logic                              ctrlDone;
    logic                              ctrlNack;
    logic [DATA_WIDTH-1:0]             dataOut;

    modport slave (
        input  reqValid, reqWrEn, reqSlvAddr, reqRegAddr, reqData,
        input  ctrlBusy, ctrlDone, ctrlNack, dataOut,
        output reqReady, rspValid, rspId, rspData, rspErr,
        output wrEn, newTXN, slvAddr, regAddr, dataIn
    );

    modport master (
        output reqValid, reqWrEn, reqSlvAddr, reqRegAddr, reqData,
        output ctrlBusy, ctrlDone, ctrlNack, dataOut,
        input  reqReady, rspValid, rspId, rspData, rspErr,
        input  wrEn, newTXN, slvAddr, regAddr, dataIn
    );
endinterface

// File: rtl/i2c_txn_arbiter_rr_arbiter.sv
// rtl/i2c_txn_arbiter_rr_arbiter.sv - round-robin grant with a pointer advanced past the last winner
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       update,
    input  logic [$clog2(NUM_REQ)-1:0] update_idx,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       grant_valid
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [IDW-1:0] ptr;

    function automatic logic [IDW-1:0] slot(input logic [IDW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IDW'(s);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (update) begin
            ptr <= (int'(update_idx) == NUM_REQ - 1) ? '0 : update_idx + IDW'(1);
        end
    end

    // Scan from farthest to nearest so the slot closest to ptr is written last and wins.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[slot(ptr, k)]) begin
                grant_valid = 1'b1;
                grant_idx   = slot(ptr, k);
                grant       = NUM_REQ'(1) << slot(ptr, k);
            end
        end
    end
endmodule

// File: rtl/i2c_txn_arbiter.sv
// rtl/i2c_txn_arbiter.sv - shares one I2C controller among NUM_REQ requesters, one transaction at a time
module i2c_txn_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input logic              clk,
    input logic              rst,
    i2c_txn_arbiter_if.slave bus
);
    import i2c_pkg::*;

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(TIMEOUT_CYCLES);
    localparam int SW  = DATA_WIDTH - 1;

    txn_state_t            state, state_next;
    logic [IDW-1:0]        g_q;
    logic                  wr_q;
    logic [SW-1:0]         slv_q;
    logic [DATA_WIDTH-1:0] reg_q, din_q, rdata_q;
    logic [1:0]            err_q;
    logic [CW-1:0]         cnt_q;
    logic [NUM_REQ-1:0]    grant;
    logic [IDW-1:0]        grant_idx;
    logic                  grant_valid;
    logic                  expired;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk         (clk),
        .rst         (rst),
        .req         (bus.reqValid),
        .update      (state == ST_RESP),
        .update_idx  (g_q),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign expired = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            g_q     <= '0;
            wr_q    <= 1'b0;
            slv_q   <= '0;
            reg_q   <= '0;
            din_q   <= '0;
            rdata_q <= '0;
            err_q   <= ERR_OK;
            cnt_q   <= '0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: if (grant_valid) begin
                    g_q   <= grant_idx;
                    wr_q  <= bus.reqWrEn[grant_idx];
                    slv_q <= bus.reqSlvAddr[int'(grant_idx)*SW +: SW];
                    reg_q <= bus.reqRegAddr[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
                    din_q <= bus.reqData[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
                end
                // The newTXN cycle itself is the first elapsed cycle, so the response
                // lands exactly TIMEOUT_CYCLES after the start pulse.
                ST_ISSUE: if (!bus.ctrlBusy) cnt_q <= CW'(1);
                ST_WAIT: begin
                    if (bus.ctrlDone) begin
                        rdata_q <= (wr_q || bus.ctrlNack) ? '0 : bus.dataOut;
                        err_q   <= bus.ctrlNack ? ERR_NACK : ERR_OK;
                    end else if (expired) begin
                        rdata_q <= '0;
                        err_q   <= ERR_TIMEOUT;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next   = state;
        bus.reqReady = '0;
        bus.newTXN   = 1'b0;
        bus.wrEn     = 1'b0;
        bus.slvAddr  = '0;
        bus.regAddr  = '0;
        bus.dataIn   = '0;
        bus.rspValid = 1'b0;
        bus.rspId    = '0;
        bus.rspData  = '0;
        bus.rspErr   = ERR_OK;
        case (state)
            ST_IDLE: begin
                bus.reqReady = grant;
                if (grant_valid) state_next = ST_ISSUE;
            end
            ST_ISSUE, ST_WAIT: begin
                bus.wrEn    = wr_q;
                bus.slvAddr = slv_q;
                bus.regAddr = reg_q;
                bus.dataIn  = din_q;
                if (state == ST_ISSUE) begin
                    bus.newTXN = !bus.ctrlBusy;
                    if (!bus.ctrlBusy) state_next = ST_WAIT;
                end else if (bus.ctrlDone || expired) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                bus.rspValid = 1'b1;
                bus.rspId    = g_q;
                bus.rspData  = rdata_q;
                bus.rspErr   = err_q;
                state_next   = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// tb/tb_i2c_txn_arbiter.sv - self-checking bench: transaction-level model plus directed scenarios
module tb_i2c_txn_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int SW = DW - 1;
    localparam int TO = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    i2c_txn_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();
    i2c_txn_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit chk_on = 1'b0;

    int done_at = -1;
    int cfg_delay = -1;
    logic cfg_nack = 1'b0;
    logic [DW-1:0] cfg_dout = '0;

    int n_acc = 0, n_new = 0, n_rsp = 0;
    int last_acc_cyc = 0, last_new_cyc = 0;
    int grant_q[$];
    int rsp_id_q[$], rsp_data_q[$], rsp_err_q[$], rsp_cyc_q[$];
    logic new_wr;
    logic [SW-1:0] new_slv;
    logic [DW-1:0] new_reg, new_din;

    int m_owner = -1, m_ptr = 0, m_age = 0;
    bit m_launched = 1'b0, m_rsp = 1'b0;
    logic m_wr;
    logic [SW-1:0] m_slv;
    logic [DW-1:0] m_reg, m_din, m_data;
    logic [1:0] m_err;

    logic [N-1:0] e_ready;
    logic e_new, e_wr, e_rv;
    logic [SW-1:0] e_slv;
    logic [DW-1:0] e_reg, e_din, e_rd;
    logic [1:0] e_id, e_err;
    int g;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scripted controller: one ctrlDone pulse cfg_delay cycles after each newTXN.
    always @(posedge clk) begin
        #1;
        bus.ctrlDone = (cyc == done_at);
        bus.ctrlNack = bus.ctrlDone & cfg_nack;
        bus.dataOut  = bus.ctrlDone ? cfg_dout : 8'h3C;
    end

    always @(negedge clk) if (chk_on) begin
        e_ready = '0; e_new = 0; e_wr = 0; e_slv = '0; e_reg = '0; e_din = '0;
        e_rv = 0; e_id = '0; e_rd = '0; e_err = '0;
        g = -1;
        if (m_rsp) begin
            e_rv = 1; e_id = 2'(m_owner); e_rd = m_data; e_err = m_err;
        end else if (m_owner < 0) begin
            g = pick(bus.reqValid, m_ptr);
            if (g >= 0) e_ready[g] = 1'b1;
        end else begin
            e_wr = m_wr; e_slv = m_slv; e_reg = m_reg; e_din = m_din;
            e_new = !m_launched && !bus.ctrlBusy;
        end
        check("reqReady", bus.reqReady, e_ready);
        check("newTXN", bus.newTXN, e_new);
        check("wrEn", bus.wrEn, e_wr);
        check("slvAddr", bus.slvAddr, e_slv);
        check("regAddr", bus.regAddr, e_reg);
        check("dataIn", bus.dataIn, e_din);
        check("rspValid", bus.rspValid, e_rv);
        check("rspId", bus.rspId, e_id);
        check("rspData", bus.rspData, e_rd);
        check("rspErr", bus.rspErr, e_err);

        for (int k = 0; k < N; k++) if (bus.reqValid[k] && bus.reqReady[k]) begin
            grant_q.push_back(k); n_acc++; last_acc_cyc = cyc;
        end
        if (bus.newTXN === 1'b1) begin
            n_new++; last_new_cyc = cyc;
            new_wr = bus.wrEn; new_slv = bus.slvAddr; new_reg = bus.regAddr; new_din = bus.dataIn;
            done_at = (cfg_delay >= 0) ? cyc + cfg_delay : -1;
        end
        if (bus.rspValid === 1'b1) begin
            n_rsp++;
            rsp_id_q.push_back(int'(bus.rspId)); rsp_data_q.push_back(int'(bus.rspData));
            rsp_err_q.push_back(int'(bus.rspErr)); rsp_cyc_q.push_back(cyc);
        end

        if (rst) begin
            m_owner = -1; m_ptr = 0; m_rsp = 0; m_launched = 0; done_at = -1;
        end else if (m_rsp) begin
            m_ptr = (m_owner + 1) % N; m_owner = -1; m_rsp = 0;
        end else if (m_owner < 0) begin
            if (g >= 0) begin
                m_owner = g; m_launched = 0; m_wr = bus.reqWrEn[g];
                m_slv = bus.reqSlvAddr[g*SW +: SW]; m_reg = bus.reqRegAddr[g*DW +: DW];
                m_din = bus.reqData[g*DW +: DW];
            end
        end else if (!m_launched) begin
            if (!bus.ctrlBusy) begin m_launched = 1; m_age = 1; end
        end else if (bus.ctrlDone) begin
            m_rsp = 1; m_err = bus.ctrlNack ? 2'd1 : 2'd0;
            m_data = (m_wr || bus.ctrlNack) ? '0 : bus.dataOut;
        end else if (m_age == TO - 1) begin
            m_rsp = 1; m_err = 2'd2; m_data = '0;
        end else begin
            m_age++;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic set_req(input int i, input logic wr, input logic [SW-1:0] s,
                           input logic [DW-1:0] r, input logic [DW-1:0] d);
        bus.reqWrEn[i] = wr;
        bus.reqSlvAddr[i*SW +: SW] = s;
        bus.reqRegAddr[i*DW +: DW] = r;
        bus.reqData[i*DW +: DW] = d;
    endtask

    task automatic wait_acc(input int target);
        int b = 0;
        while (n_acc < target && b < 200) begin step(); b++; end
        check("accept_wait", 64'(n_acc >= target), 64'd1);
    endtask

    task automatic wait_rsp(input int target, input int budget);
        int b = 0;
        while (n_rsp < target && b < budget) begin step(); b++; end
        check("response_wait", 64'(n_rsp >= target), 64'd1);
    endtask

    task automatic check_last_rsp(input string tag, input int id, input int data, input int err);
        if (rsp_id_q.size() > 0) begin
            check({tag, "_id"}, 64'(rsp_id_q[$]), 64'(id));
            check({tag, "_data"}, 64'(rsp_data_q[$]), 64'(data));
            check({tag, "_err"}, 64'(rsp_err_q[$]), 64'(err));
        end
    endtask

    int nb, rel, nr0, nn0, b0;
    int rr_exp[5] = '{0, 1, 2, 3, 0};

    initial begin
        bus.reqValid = '0; bus.reqWrEn = '0; bus.reqSlvAddr = '0;
        bus.reqRegAddr = '0; bus.reqData = '0; bus.ctrlBusy = 1'b0;
        step(3);
        rst = 1'b0; chk_on = 1'b1;
        check("reset_outputs", {bus.reqReady, bus.newTXN, bus.wrEn, bus.slvAddr, bus.regAddr,
              bus.dataIn, bus.rspValid, bus.rspId, bus.rspData, bus.rspErr}, 64'd0);

        // Single write from requester 0
        set_req(0, 1'b1, 7'd10, 8'd1, 8'd3); cfg_delay = 50; cfg_nack = 0; cfg_dout = 8'hEE;
        bus.reqValid[0] = 1'b1; wait_acc(1); bus.reqValid[0] = 1'b0;
        wait_rsp(1, 100);
        check("wr_new_latency", 64'(last_new_cyc - last_acc_cyc), 64'd1);
        check("wr_fields", {new_wr, new_slv, new_reg, new_din}, {1'b1, 7'd10, 8'd1, 8'd3});
        check("wr_rsp_latency", 64'(rsp_cyc_q[$] - last_new_cyc), 64'd51);
        check_last_rsp("wr", 0, 0, 0);

        // Reads from requester 2: NACK, then data
        set_req(2, 1'b0, 7'h2A, 8'h10, 8'h00); cfg_delay = 5; cfg_nack = 1; cfg_dout = 8'h99;
        bus.reqValid[2] = 1'b1; wait_acc(2); bus.reqValid[2] = 1'b0;
        wait_rsp(2, 100);
        check("rd_fields", {new_wr, new_slv, new_reg}, {1'b0, 7'h2A, 8'h10});
        check_last_rsp("rd_nack", 2, 0, 1);
        cfg_nack = 0; cfg_dout = 8'hA5;
        bus.reqValid[2] = 1'b1; wait_acc(3); bus.reqValid[2] = 1'b0;
        wait_rsp(3, 100);
        check_last_rsp("rd_ok", 2, 8'hA5, 0);

        // Busy controller, then timeout
        bus.ctrlBusy = 1'b1; set_req(1, 1'b1, 7'h33, 8'h44, 8'h55); cfg_delay = -1;
        bus.reqValid[1] = 1'b1; wait_acc(4); bus.reqValid[1] = 1'b0;
        nb = n_new; step(20);
        check("busy_holds_newTXN", 64'(n_new - nb), 64'd0);
        bus.ctrlBusy = 1'b0; rel = cyc;
        wait_rsp(4, TO + 50);
        check("busy_release_new", 64'(last_new_cyc), 64'(rel));
        check("timeout_latency", 64'(rsp_cyc_q[$] - last_new_cyc), 64'(TO));
        check_last_rsp("timeout", 1, 0, 2);

        // ctrlDone on the terminal timeout cycle
        set_req(3, 1'b0, 7'h05, 8'h06, 8'h00); cfg_delay = TO - 1; cfg_dout = 8'h5C;
        bus.reqValid[3] = 1'b1; wait_acc(5); bus.reqValid[3] = 1'b0;
        wait_rsp(5, TO + 50);
        check("collide_latency", 64'(rsp_cyc_q[$] - last_new_cyc), 64'(TO));
        check_last_rsp("collide", 3, 8'h5C, 0);
        step(TO + 20);
        check("collide_single_rsp", 64'(n_rsp), 64'd5);

        // Round-robin with all requesters holding reqValid
        for (int i = 0; i < N; i++) set_req(i, 1'b0, SW'(i + 1), DW'(i), 8'h00);
        cfg_delay = 3; cfg_dout = 8'h11;
        b0 = grant_q.size(); nr0 = n_rsp; nn0 = n_new;
        bus.reqValid = '1; wait_acc(n_acc + 5); bus.reqValid = '0;
        wait_rsp(nr0 + 5, 200);
        for (int k = 0; k < 5; k++)
            if (grant_q.size() > b0 + k) check($sformatf("rr_grant%0d", k), 64'(grant_q[b0 + k]), 64'(rr_exp[k]));
        check("rr_new_count", 64'(n_new - nn0), 64'd5);
        check("rr_rsp_count", 64'(n_rsp - nr0), 64'd5);

        // Reset during WAIT
        set_req(2, 1'b1, 7'h11, 8'h22, 8'h33); cfg_delay = -1;
        bus.reqValid[2] = 1'b1; wait_acc(n_acc + 1); bus.reqValid[2] = 1'b0;
        step(5); nr0 = n_rsp;
        rst = 1'b1; step(); rst = 1'b0;
        check("post_rst_outputs", {bus.reqReady, bus.newTXN, bus.wrEn, bus.slvAddr, bus.regAddr,
              bus.dataIn, bus.rspValid, bus.rspId, bus.rspData, bus.rspErr}, 64'd0);
        step(10);
        check("post_rst_no_rsp", 64'(n_rsp - nr0), 64'd0);
        set_req(0, 1'b0, 7'h01, 8'h02, 8'h00); set_req(3, 1'b0, 7'h03, 8'h04, 8'h00);
        cfg_delay = 2; cfg_dout = 8'h7E;
        bus.reqValid = 4'b1001; wait_acc(n_acc + 1); bus.reqValid = '0;
        check("post_rst_grant", 64'(grant_q[$]), 64'd0);
        wait_rsp(nr0 + 1, 100);
        check_last_rsp("post_rst", 0, 8'h7E, 0);

        step(5);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
        $fatal(1);
    end
endmodule
